// File: rtl/debounce_bank_if.sv
// debounce_bank_if: raw button inputs and debounced outputs of debounce_bank.
// master drives the raw pins, slave is the debouncer itself.
interface debounce_bank_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] buttons;
    logic [NUM_CH-1:0] debounced;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic              any_event;
    logic [NUM_CH-1:0] repeat_pulse;

    modport master (
        output buttons,
        input  debounced, rise, fall, any_event, repeat_pulse
    );

    modport slave (
        input  buttons,
        output debounced, rise, fall, any_event, repeat_pulse
    );
endinterface

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchroniser, stability counter and edge pulses.
// Optional auto-repeat pulses are built only when BTN_REPEAT_EN is defined.
module debounce_bank #(
    parameter int NUM_CH        = 4,
    parameter int COUNT_MAX     = 1250000,
    parameter int CNT_W         = 21,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000,
    parameter int RPT_W         = 24
) (
    input  logic           clock_25,
    input  logic           reset,
    debounce_bank_if.slave bus
);
    typedef enum logic {IDLE, COUNT} state_t;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] debounced_q, debounced_d;
    logic [NUM_CH-1:0] rise_q, rise_d;
    logic [NUM_CH-1:0] fall_q, fall_d;
    logic              any_event_q, any_event_d;
    logic [NUM_CH-1:0] s;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift raw pins through the synchroniser chain.
    always_comb begin
        sync_d[0] = bus.buttons;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Stability FSM per channel; commit after COUNT_MAX differing samples.
    always_comb begin
        debounced_d = debounced_q;
        rise_d      = '0;
        fall_d      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            unique case (state_q[i])
                IDLE: begin
                    if (s[i] != debounced_q[i]) begin
                        state_d[i] = COUNT;
                    end
                end
                COUNT: begin
                    if (s[i] == debounced_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == CNT_W'(COUNT_MAX - 1)) begin
                        state_d[i]     = IDLE;
                        debounced_d[i] = s[i];
                        rise_d[i]      = s[i];
                        fall_d[i]      = ~s[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
        any_event_d = |(rise_d | fall_d);
    end

    // State, counters, synchroniser and registered outputs.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            debounced_q <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            any_event_q <= 1'b0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            debounced_q <= debounced_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            any_event_q <= any_event_d;
        end
    end

    assign bus.debounced = debounced_q;
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
    assign bus.any_event = any_event_q;

`ifdef BTN_REPEAT_EN
    logic [RPT_W-1:0]  rpt_cnt_q [NUM_CH];
    logic [RPT_W-1:0]  rpt_cnt_d [NUM_CH];
    logic [NUM_CH-1:0] rpt_done_q, rpt_done_d;
    logic [NUM_CH-1:0] repeat_q, repeat_d;

    // Held-press timer: first pulse after the delay, then periodic.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            rpt_cnt_d[i]  = rpt_cnt_q[i] + 1'b1;
            rpt_done_d[i] = rpt_done_q[i];
            repeat_d[i]   = 1'b0;
            if (!debounced_q[i] || fall_d[i]) begin
                rpt_cnt_d[i]  = '0;
                rpt_done_d[i] = 1'b0;
            end else if (rpt_done_q[i]
                         ? (rpt_cnt_q[i] == RPT_W'(REPEAT_PERIOD - 1))
                         : (rpt_cnt_q[i] == RPT_W'(REPEAT_DELAY - 1))) begin
                repeat_d[i]   = 1'b1;
                rpt_cnt_d[i]  = '0;
                rpt_done_d[i] = 1'b1;
            end
        end
    end

    // Repeat counter and pulse registers.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rpt_cnt_q[i] <= '0;
            end
            rpt_done_q <= '0;
            repeat_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
            rpt_done_q <= rpt_done_d;
            repeat_q   <= repeat_d;
        end
    end

    assign bus.repeat_pulse = repeat_q;
`else
    assign bus.repeat_pulse = '0;
`endif
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed and random stimulus for debounce_bank,
// checked every cycle against a sample-history model.
module tb_debounce_bank;
    localparam int NCH = 4;
    localparam int CM  = 8;
    localparam int SS  = 2;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int HL  = 64;

    logic clock_25 = 1'b0;
    logic reset    = 1'b0;

    debounce_bank_if #(.NUM_CH(NCH)) bus ();

    debounce_bank #(
        .NUM_CH(NCH), .COUNT_MAX(CM), .CNT_W(4), .SYNC_STAGES(SS),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .RPT_W(8)
    ) dut (
        .clock_25(clock_25),
        .reset(reset),
        .bus(bus)
    );

    always #20 clock_25 = ~clock_25;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model state: raw samples per edge since reset, committed levels,
    // edge of last commit and edge of last rise per channel.
    logic [NCH-1:0] hist [HL];
    int             n;
    logic [NCH-1:0] m_deb, m_rise, m_fall, m_rep;
    logic           m_any;
    int             last_commit [NCH];
    int             rise_at [NCH];
    int             rcnt [NCH];
    int             acnt;
    bit             ok;
    logic           sv;
    int             idx;

    initial begin
        acnt = 0;
        for (int c = 0; c < NCH; c++) rcnt[c] = 0;
    end

    // A channel commits at edge n when the synchronised level seen by the
    // last CM+1 edges all differ from the committed level and none of
    // those edges precede the previous commit.
    always @(posedge clock_25) begin
        m_rise = '0;
        m_fall = '0;
        m_rep  = '0;
        if (!reset) begin
            n     = 0;
            m_deb = '0;
            for (int c = 0; c < NCH; c++) begin
                last_commit[c] = -1000;
                rise_at[c]     = -1;
            end
        end else begin
            hist[n % HL] = bus.buttons;
            for (int c = 0; c < NCH; c++) begin
                ok = (n - last_commit[c]) > CM;
                for (int j = 0; j <= CM; j++) begin
                    idx = n - SS - j;
                    sv  = (idx >= 0) ? hist[idx % HL][c] : 1'b0;
                    if (sv == m_deb[c]) ok = 1'b0;
                end
`ifdef BTN_REPEAT_EN
                if (m_deb[c] && !ok && rise_at[c] >= 0 &&
                    (n - rise_at[c]) >= RD &&
                    ((n - rise_at[c] - RD) % RP) == 0)
                    m_rep[c] = 1'b1;
`endif
                if (ok) begin
                    last_commit[c] = n;
                    if (m_deb[c]) begin
                        m_fall[c]  = 1'b1;
                        rise_at[c] = -1;
                    end else begin
                        m_rise[c]  = 1'b1;
                        rise_at[c] = n;
                    end
                    m_deb[c] = ~m_deb[c];
                end
            end
            n++;
        end
        m_any = |(m_rise | m_fall);
        #1;
        chk("debounced", bus.debounced, m_deb);
        chk("rise", bus.rise, m_rise);
        chk("fall", bus.fall, m_fall);
        chk("any_event", bus.any_event, m_any);
        chk("repeat", bus.repeat_pulse, m_rep);
        for (int c = 0; c < NCH; c++) rcnt[c] += int'(bus.rise[c]);
        acnt += int'(bus.any_event);
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clock_25);
    endtask

    task automatic wait_level(input int ch, input logic lvl, output int k);
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock_25);
            #2;
            if (bus.debounced[ch] === lvl) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_rep(input int ch, output int k);
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock_25);
            #2;
            if (bus.repeat_pulse[ch] === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    int k, r0, a0;
    int hold [NCH];

    initial begin
        bus.buttons = '0;
        tick(3);
        chk("reset_deb", bus.debounced, 4'b0000);
        chk("reset_any", bus.any_event, 1'b0);
        reset = 1'b1;
        tick(3);

        // Clean press on channel 0.
        bus.buttons = 4'b0001;
        wait_level(0, 1'b1, k);
        chk("press_latency", k, 11);
        chk("press_rise", bus.rise, 4'b0001);
        chk("press_any", bus.any_event, 1'b1);
        chk("press_fall", bus.fall, 4'b0000);
`ifdef BTN_REPEAT_EN
        wait_rep(0, k);
        chk("rep_first", k, RD);
        wait_rep(0, k);
        chk("rep_period", k, RP);
        tick(3);
`else
        tick(40);
        chk("no_repeat", bus.repeat_pulse, 4'b0000);
`endif
        @(negedge clock_25);
        bus.buttons = 4'b0000;
        wait_level(0, 1'b0, k);
        chk("release_latency", k, 11);
        chk("release_fall", bus.fall, 4'b0001);
        tick(5);

        // Bounce on channel 1.
        r0 = rcnt[1];
        bus.buttons[1] = 1'b1; tick(3);
        bus.buttons[1] = 1'b0; tick(3);
        bus.buttons[1] = 1'b1; tick(3);
        bus.buttons[1] = 1'b0; tick(3);
        bus.buttons[1] = 1'b1;
        wait_level(1, 1'b1, k);
        chk("bounce_latency", k, 11);
        tick(3);
        chk("bounce_rises", rcnt[1] - r0, 1);

        // Glitch on channel 2.
        a0 = acnt;
        bus.buttons[2] = 1'b1; tick(7);
        bus.buttons[2] = 1'b0; tick(30);
        chk("glitch_any", acnt - a0, 0);
        chk("glitch_deb", bus.debounced[2], 1'b0);

        // Simultaneous press and release.
        bus.buttons = 4'b0000;
        tick(20);
        a0 = acnt;
        bus.buttons = 4'b1111;
        wait_level(0, 1'b1, k);
        chk("simul_latency", k, 11);
        chk("simul_rise", bus.rise, 4'b1111);
        tick(3);
        chk("simul_any_once", acnt - a0, 1);
        bus.buttons = 4'b0000;
        wait_level(0, 1'b0, k);
        chk("simul_rel_latency", k, 11);
        chk("simul_fall", bus.fall, 4'b1111);
        tick(20);

        // Reset in the middle of a count on channel 3.
        r0 = rcnt[3];
        bus.buttons[3] = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(2);
        chk("rst_deb", bus.debounced, 4'b0000);
        reset = 1'b1;
        chk("rst_no_pulse", rcnt[3] - r0, 0);
        wait_level(3, 1'b1, k);
        chk("rst_relatch", k, 11);
        tick(5);

        // Random holds: mostly short glitches, some long presses.
        for (int c = 0; c < NCH; c++) hold[c] = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    bus.buttons[c] = ~bus.buttons[c];
                    hold[c] = ($urandom_range(0, 3) == 0)
                              ? int'($urandom_range(20, 60))
                              : int'($urandom_range(1, 12));
                end
            end
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                tick($urandom_range(1, 3));
                reset = 1'b1;
            end
            tick(1);
        end
        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised multi-channel debouncer for front-panel buttons and switches.
- Each channel has its own synchroniser, its own stability counter and its own press/release edge pulses.
- Sits between the raw board I/O pins and the game/control logic in the clock_25 domain.
- A raw input must hold a new level for COUNT_MAX consecutive cycles before it is committed; any glitch restarts the count.

Parameters:
- NUM_CH, 4: number of independent channels.
- COUNT_MAX, 1250000: stable cycles needed to commit a change (0.05 s at 25 MHz); legal range >= 1.
- CNT_W, 21: stability counter width; must satisfy 2^CNT_W > COUNT_MAX.
- SYNC_STAGES, 2: synchroniser flops per channel; legal range >= 2.
- REPEAT_DELAY, 12500000: cycles a press is held before the first repeat pulse (used only with the optional feature).
- REPEAT_PERIOD, 2500000: cycles between later repeat pulses (used only with the optional feature).
- RPT_W, 24: repeat counter width; must hold the larger of REPEAT_DELAY and REPEAT_PERIOD.

Ports:
- clock_25  input  1  system clock, 25 MHz.
- reset  input  1  asynchronous, active-low reset.
- buttons  input  NUM_CH  raw asynchronous inputs; bit i is channel i.
- debounced  output  NUM_CH  committed stable levels.
- rise  output  NUM_CH  one-cycle pulse when debounced[i] goes 0->1.
- fall  output  NUM_CH  one-cycle pulse when debounced[i] goes 1->0.
- any_event  output  1  registered OR of rise|fall, same cycle as the pulses.
- repeat  output  NUM_CH  auto-repeat pulses; present only with BTN_REPEAT_EN, otherwise driven 0.

Behaviour:
- Clock and reset: clock_25 domain, with reset asynchronous and active-low. All logic, including the synchroniser flops, is asynchronously reset.
- Reset values: debounced, rise, fall, any_event and repeat = 0. Counters = 0, every FSM in IDLE.
- Synchroniser: each buttons[i] passes through SYNC_STAGES flops; the last stage is s[i]. All channel logic uses s[i] only.
- Per-channel FSM, two states:
  - IDLE: counter = 0. If s[i] != debounced[i], go to COUNT with counter = 0.
  - COUNT, s[i] == debounced[i] (bounce back): return to IDLE, counter = 0, no output change.
  - COUNT, s[i] != debounced[i] and counter == COUNT_MAX-1: debounced[i] <= s[i]; pulse rise[i] or fall[i] for exactly one cycle; return to IDLE.
  - COUNT, any other case: counter + 1.
- Latency: debounced[i] changes SYNC_STAGES+COUNT_MAX+1 rising edges after the first edge that samples the new raw level, provided the level stays steady.
- Pulse timing: rise/fall are asserted in the same cycle debounced first shows the new value. They are never asserted on two consecutive cycles for one channel.
- Channel independence: channels share nothing. Simultaneous commits on several channels each produce their own pulse, and any_event is a single-cycle 1.
- Wrap-around: the counter never exceeds COUNT_MAX-1, so no overflow path exists.
- Reset mid-count: aborts the count immediately and drops all outputs to 0, with no pulse. After reset release, a held-high input needs the full latency to re-commit.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- With the macro, each channel has an RPT_W repeat counter:
  - The counter clears on rise[i] and while debounced[i] == 0.
  - While debounced[i] == 1, it counts. repeat[i] pulses for one cycle REPEAT_DELAY cycles after rise[i], then every REPEAT_PERIOD cycles after that.
  - fall[i] or reset stops repeating at once.
  - repeat is never coincident with rise.
- Without the macro: no repeat counters are built and repeat is tied to 0. All other behaviour is identical.

Test Plan (bench uses COUNT_MAX=8, SYNC_STAGES=2, NUM_CH=4, REPEAT_DELAY=20, REPEAT_PERIOD=5):
- Clean press: buttons 0000->0001 held -> debounced[0]=1 exactly 11 edges later, rise=0001 for one cycle, any_event=1 in the same cycle, fall=0.
- Bounce: buttons[1] toggles 1,0,1,0 every 3 cycles, then steady 1 -> no output until 11 edges after the last transition; then one rise[1] pulse only.
- Glitch reject: buttons[2] high for 7 cycles, then low -> debounced, rise and any_event stay 0 throughout.
- Simultaneous: buttons 0000->1111 in one cycle -> rise=1111 for one cycle, any_event a single one-cycle pulse; release 1111->0000 -> fall=1111 for one cycle after 11 edges.
- Reset mid-count: buttons[3]=1, reset low at cycle 5 for 2 cycles, input still high -> outputs stay 0, no pulse; debounced[3]=1 eleven edges after reset release.
- BTN_REPEAT_EN: hold buttons[0] -> repeat[0] pulses 20 cycles after rise[0], then every 5 cycles; release -> repeat stops, and fall[0] follows 11 edges later. Without the macro, repeat stays 0000.
